// File: rtl/fp_entry_pkg.sv
// fp_entry_pkg: state encoding, operand width helper and error display constant shared by fp_operand_entry
package fp_entry_pkg;
  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    SHOW    = 3'd4
  } state_t;
  localparam logic [63:0] ERROR_DISPLAY = '1;
  function automatic int width(input int digits);
    return digits * 4;
  endfunction
endpackage

// File: rtl/fp_operand_entry_sync_edge.sv
// sync_edge: 2-flop synchronizer plus rising-edge pulse (clk, reset, din async level -> pulse one-cycle event)
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);
  logic [2:0] s;
  always_ff @(posedge clk) s <= reset ? 3'b000 : {s[1:0], din};
  assign pulse = s[1] & ~s[2];
endmodule

// File: rtl/fp_operand_entry.sv
// fp_operand_entry: keypad hex entry of two operands, adder start/done handshake with timeout, result display (ports: clk, reset, key_value/key_valid, enter, clear, sub, add_done/add_result in; op_a, op_b, op_sub, start, display, state_out, error out)
module fp_operand_entry
  import fp_entry_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 key_value,
  input  logic                       key_valid,
  input  logic                       enter,
  input  logic                       clear,
  input  logic                       sub,
  input  logic                       add_done,
  input  logic [width(DIGITS)-1:0]   add_result,
  output logic [width(DIGITS)-1:0]   op_a,
  output logic [width(DIGITS)-1:0]   op_b,
  output logic                       op_sub,
  output logic                       start,
  output logic [width(DIGITS)-1:0]   display,
  output logic [2:0]                 state_out,
  output logic                       error
);
  localparam int W  = width(DIGITS);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(DIGITS + 1);
  state_t state, nxt;
  logic key_evt, enter_evt, clr_evt, timeout, abort;
  logic [W-1:0] entry, result;
  logic [DW-1:0] digits;
  logic [CW-1:0] cnt;
  sync_edge u_key   (.clk(clk), .reset(reset), .din(key_valid), .pulse(key_evt));
  sync_edge u_enter (.clk(clk), .reset(reset), .din(enter),     .pulse(enter_evt));
  sync_edge u_clear (.clk(clk), .reset(reset), .din(clear),     .pulse(clr_evt));
  assign timeout = cnt == CW'(TIMEOUT - 1);
  assign abort   = clr_evt | (enter_evt & (state == SHOW) & error);
  always_ff @(posedge clk) state <= reset ? ENTER_A : nxt;
  always_comb begin
    nxt = state;
    if (abort) nxt = ENTER_A;
    else case (state)
      ENTER_A: nxt = enter_evt ? ENTER_B : ENTER_A;
      ENTER_B: nxt = enter_evt ? ISSUE : ENTER_B;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = (add_done || timeout) ? SHOW : WAIT;
      SHOW:    nxt = enter_evt ? ENTER_B : key_evt ? ENTER_A : SHOW;
      default: nxt = ENTER_A;
    endcase
  end
  always_comb begin
    start     = state == ISSUE;
    display   = (state == ENTER_A || state == ENTER_B) ? entry : (state == SHOW) ? result : op_b;
    state_out = state;
  end
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      entry  <= '0;
      digits <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_sub <= 1'b0;
      result <= '0;
      error  <= 1'b0;
      cnt    <= '0;
    end else begin
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      case (state)
        ENTER_A, ENTER_B:
          if (enter_evt) begin
            if (state == ENTER_A) op_a <= entry;
            else begin
              op_b   <= entry;
              op_sub <= sub;
            end
            entry  <= '0;
            digits <= '0;
          end else if (key_evt) begin
            entry  <= {entry[W-5:0], key_value};
            digits <= (digits == DW'(DIGITS)) ? digits : digits + 1'b1;
          end
        WAIT:
          if (add_done) result <= add_result;
          else if (timeout) begin
            error  <= 1'b1;
            result <= ERROR_DISPLAY[W-1:0];
          end
        SHOW:
          if (enter_evt) op_a <= result;
          else if (key_evt) begin
            entry  <= {{(W-4){1'b0}}, key_value};
            digits <= DW'(1);
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_operand_entry.sv
// tb_fp_operand_entry: directed and randomized checks of fp_operand_entry against a cycle-level behavioural model
module tb_fp_operand_entry;
  localparam int DIGITS = 4;
  localparam int W = 16;
  localparam int TIMEOUT = 20;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] key_value = 4'h0;
  logic key_valid = 1'b0, enter = 1'b0, clear = 1'b0, sub = 1'b0, add_done = 1'b0;
  logic [W-1:0] add_result = '0;
  logic [W-1:0] op_a, op_b, display;
  logic op_sub, start, error;
  logic [2:0] state_out;
  int checks = 0, failures = 0;
  fp_operand_entry #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .key_value(key_value), .key_valid(key_valid),
    .enter(enter), .clear(clear), .sub(sub), .add_done(add_done), .add_result(add_result),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .start(start), .display(display),
    .state_out(state_out), .error(error)
  );
  always #5 clk = ~clk;
  int m_state = 0, m_wait = 0;
  logic [W-1:0] m_entry = '0, m_a = '0, m_b = '0, m_res = '0;
  logic m_sub = 1'b0, m_err = 1'b0;
  bit m_live = 1'b0;
  bit [2:0] hk = '0, he = '0, hc = '0;
  task automatic model_clear();
    m_state = 0;
    m_wait  = 0;
    m_entry = '0;
    m_a     = '0;
    m_b     = '0;
    m_res   = '0;
    m_sub   = 1'b0;
    m_err   = 1'b0;
  endtask
  // Events are the pin level two samples ago rising against three samples ago.
  always @(posedge clk) begin
    bit ke, ee, ce;
    if (reset) begin
      model_clear();
      hk = '0;
      he = '0;
      hc = '0;
      m_live = 1'b1;
    end else begin
      ke = hk[1] && !hk[2];
      ee = he[1] && !he[2];
      ce = hc[1] && !hc[2];
      if (ce || (ee && m_state == 4 && m_err)) model_clear();
      else case (m_state)
        0, 1:
          if (ee) begin
            if (m_state == 0) m_a = m_entry;
            else begin
              m_b = m_entry;
              m_sub = sub;
            end
            m_entry = '0;
            m_state = m_state + 1;
          end else if (ke) m_entry = {m_entry[W-5:0], key_value};
        2: begin
          m_state = 3;
          m_wait = 0;
        end
        3:
          if (add_done) begin
            m_res = add_result;
            m_state = 4;
          end else begin
            m_wait = m_wait + 1;
            if (m_wait == TIMEOUT) begin
              m_err = 1'b1;
              m_res = '1;
              m_state = 4;
            end
          end
        4:
          if (ee) begin
            m_a = m_res;
            m_state = 1;
          end else if (ke) begin
            m_entry = {12'h000, key_value};
            m_state = 0;
          end
        default: m_state = 0;
      endcase
      hk = {hk[1:0], key_valid};
      he = {he[1:0], enter};
      hc = {hc[1:0], clear};
    end
  end
  logic adder_en = 1'b0, rnd = 1'b0;
  int adder_lat = 5, r_lat;
  logic [W-1:0] adder_res = '0, r_val;
  initial forever begin
    @(posedge clk);
    #2;
    if (start && adder_en) begin
      r_lat = rnd ? int'($urandom_range(1, TIMEOUT + 2)) : adder_lat;
      r_val = rnd ? W'($urandom) : adder_res;
      repeat (r_lat) @(posedge clk);
      #2;
      add_done = 1'b1;
      add_result = r_val;
      @(posedge clk);
      #2;
      add_done = 1'b0;
    end else if (rnd && $urandom_range(0, 40) == 0) begin
      add_done = 1'b1;
      add_result = W'($urandom);
      @(posedge clk);
      #2;
      add_done = 1'b0;
    end
  end
  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic compare();
    logic [W-1:0] d;
    if (!m_live) return;
    d = (m_state <= 1) ? m_entry : (m_state == 4) ? m_res : m_b;
    chk("state_out", W'(state_out), W'(m_state));
    chk("op_a", op_a, m_a);
    chk("op_b", op_b, m_b);
    chk("op_sub", W'(op_sub), W'(m_sub));
    chk("start", W'(start), W'(m_state == 2));
    chk("display", display, d);
    chk("error", W'(error), W'(m_err));
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      compare();
      @(posedge clk);
      #1;
    end
  endtask
  task automatic press(input logic [3:0] k);
    key_value = k;
    key_valid = 1'b1;
    cyc(4);
    key_valid = 1'b0;
    cyc(4);
  endtask
  task automatic do_enter();
    enter = 1'b1;
    cyc(4);
    enter = 1'b0;
    cyc(4);
  endtask
  task automatic do_clear();
    clear = 1'b1;
    cyc(4);
    clear = 1'b0;
    cyc(4);
  endtask
  initial begin
    @(posedge clk);
    #1;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("rst_state", W'(state_out), 16'h0000);
    chk("rst_op_a", op_a, 16'h0000);
    chk("rst_display", display, 16'h0000);
    chk("rst_start", W'(start), 16'h0000);
    chk("rst_error", W'(error), 16'h0000);
    adder_en = 1'b1;
    adder_lat = 5;
    adder_res = 16'h4300;
    press(4'h3); press(4'hC); press(4'h0); press(4'h0);
    do_enter();
    press(4'h4); press(4'h0); press(4'h0); press(4'h0);
    sub = 1'b0;
    do_enter();
    cyc(10);
    chk("add_op_a", op_a, 16'h3C00);
    chk("add_op_b", op_b, 16'h4000);
    chk("add_op_sub", W'(op_sub), 16'h0000);
    chk("add_display", display, 16'h4300);
    chk("add_state", W'(state_out), 16'h0004);
    do_enter();
    chk("chain_op_a", op_a, 16'h4300);
    chk("chain_state", W'(state_out), 16'h0001);
    adder_lat = 3;
    adder_res = 16'h1234;
    press(4'hB); press(4'hC); press(4'h0); press(4'h0);
    sub = 1'b1;
    do_enter();
    cyc(10);
    chk("chain_op_b", op_b, 16'hBC00);
    chk("chain_op_sub", W'(op_sub), 16'h0001);
    chk("chain_display", display, 16'h1234);
    do_clear();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    do_enter();
    chk("ovf_op_a", op_a, 16'h2345);
    key_value = 4'h7;
    key_valid = 1'b1;
    cyc(20);
    key_valid = 1'b0;
    cyc(4);
    chk("hold_display", display, 16'h0007);
    adder_en = 1'b0;
    do_enter();
    cyc(TIMEOUT + 10);
    chk("to_error", W'(error), 16'h0001);
    chk("to_display", display, 16'hFFFF);
    chk("to_state", W'(state_out), 16'h0004);
    do_enter();
    chk("to_clr_state", W'(state_out), 16'h0000);
    chk("to_clr_op_a", op_a, 16'h0000);
    chk("to_clr_error", W'(error), 16'h0000);
    adder_en = 1'b1;
    adder_lat = 12;
    adder_res = 16'h5555;
    press(4'h1);
    do_enter();
    press(4'h2);
    enter = 1'b1;
    cyc(6);
    enter = 1'b0;
    clear = 1'b1;
    cyc(4);
    clear = 1'b0;
    cyc(20);
    chk("cw_state", W'(state_out), 16'h0000);
    chk("cw_op_a", op_a, 16'h0000);
    chk("cw_display", display, 16'h0000);
    chk("cw_error", W'(error), 16'h0000);
    adder_lat = TIMEOUT;
    adder_res = 16'h7777;
    press(4'hA);
    do_enter();
    press(4'hB);
    do_enter();
    cyc(TIMEOUT + 5);
    chk("tie_error", W'(error), 16'h0000);
    chk("tie_display", display, 16'h7777);
    adder_lat = TIMEOUT + 1;
    do_enter();
    do_enter();
    cyc(TIMEOUT + 5);
    chk("late_error", W'(error), 16'h0001);
    chk("late_display", display, 16'hFFFF);
    do_clear();
    press(4'h1);
    press(4'h2);
    key_value = 4'h5;
    key_valid = 1'b1;
    enter = 1'b1;
    cyc(4);
    key_valid = 1'b0;
    enter = 1'b0;
    cyc(4);
    chk("ke_op_a", op_a, 16'h0012);
    chk("ke_display", display, 16'h0000);
    chk("ke_state", W'(state_out), 16'h0001);
    do_clear();
    press(4'h7);
    press(4'h7);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(1);
    chk("rme_display", display, 16'h0000);
    chk("rme_state", W'(state_out), 16'h0000);
    press(4'h9);
    chk("rme_key9", display, 16'h0009);
    rnd = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 10))
        0, 1, 2, 3, 4: press(4'($urandom));
        5, 6: begin
          sub = 1'($urandom);
          do_enter();
        end
        7: do_clear();
        8: cyc(int'($urandom_range(1, 25)));
        9: begin
          key_value = 4'($urandom);
          key_valid = 1'b1;
          enter = 1'b1;
          cyc(4);
          key_valid = 1'b0;
          enter = 1'b0;
          cyc(4);
        end
        default:
          if ($urandom_range(0, 3) == 0) begin
            reset = 1'b1;
            cyc(1);
            reset = 1'b0;
            cyc(1);
          end else cyc(2);
      endcase
    end
    rnd = 1'b0;
    cyc(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
